// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD framebuffer writer.
// The writer packs 2-bit shades four to a byte and tracks its own screen position.
package lcd_pkg;

  localparam int LCD_WIDTH           = 160;
  localparam int LCD_HEIGHT          = 144;
  localparam int LCD_WORDS_PER_LINE  = 40;
  localparam int LCD_PIXELS_PER_WORD = 4;

  typedef logic [1:0] lcd_shade_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } lcd_wr_state_t;

endpackage

// File: rtl/lcd_framebuffer_writer_if.sv
// Pixel-stream input and framebuffer-write output bundle for lcd_framebuffer_writer.
// Handshake: pixel_valid_in is a one-cycle strobe with no ready; every strobe is consumed.
interface lcd_framebuffer_writer_if #(
  parameter int FB_ADDR_WIDTH = 13
);
  import lcd_pkg::*;

  logic                     enable_in;
  logic                     frame_start_in;
  lcd_shade_t               pixel_in;
  logic                     pixel_valid_in;
  logic [FB_ADDR_WIDTH-1:0] fb_addr_out;
  logic [7:0]               fb_data_out;
  logic                     fb_we_out;
  logic [7:0]               x_out;
  logic [7:0]               y_out;
  logic                     line_done_out;
  logic                     frame_done_out;
  logic                     overrun_out;
  lcd_wr_state_t            state;

  modport slave (
    input  enable_in, frame_start_in, pixel_in, pixel_valid_in,
    output fb_addr_out, fb_data_out, fb_we_out, x_out, y_out,
           line_done_out, frame_done_out, overrun_out, state
  );

  modport master (
    output enable_in, frame_start_in, pixel_in, pixel_valid_in,
    input  fb_addr_out, fb_data_out, fb_we_out, x_out, y_out,
           line_done_out, frame_done_out, overrun_out, state
  );

endinterface

// File: rtl/pixel_packer.sv
// Shift/pack unit: four 2-bit shades in, one byte out, first pixel in bits [1:0].
// word is the byte including the current shade, valid when word_ready pulses.
module pixel_packer
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       accept,
  input  lcd_shade_t shade,
  input  logic [1:0] slot,
  output logic [7:0] word,
  output logic       word_ready
);

  logic [7:0] sr;

  // New shades enter at the top; after four shifts the first sits in [1:0].
  assign word       = {shade, sr[7:2]};
  assign word_ready = accept && (slot == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= 8'h00;
    end else if (accept) begin
      sr <= clear ? {shade, 6'b000000} : word;
    end else if (clear) begin
      sr <= 8'h00;
    end
  end

endmodule

// File: rtl/lcd_framebuffer_writer.sv
// Sink of the PPU pixel stream: tracks X/Y, packs pixels into bytes and writes
// them to the framebuffer BRAM, flagging line/frame completion and overruns.
module lcd_framebuffer_writer
  import lcd_pkg::*;
#(
  parameter int X_MAX         = LCD_WIDTH,
  parameter int Y_MAX         = LCD_HEIGHT,
  parameter int FB_ADDR_WIDTH = 13
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  lcd_framebuffer_writer_if.slave bus
);

  localparam logic [FB_ADDR_WIDTH-1:0] WORDS_PER_LINE =
    FB_ADDR_WIDTH'(X_MAX / LCD_PIXELS_PER_WORD);
  localparam logic [7:0] LAST_COL = 8'(X_MAX - 1);
  localparam logic [7:0] LAST_ROW = 8'(Y_MAX - 1);

  lcd_wr_state_t            state;
  logic [7:0]               x;
  logic [7:0]               y;
  logic [FB_ADDR_WIDTH-1:0] row_base;
  logic [FB_ADDR_WIDTH-1:0] fb_addr;
  logic [7:0]               fb_data;
  logic                     fb_we;
  logic                     line_done;
  logic                     frame_done;
  logic                     overrun;

  logic                     start;
  logic                     accept;
  logic                     clear;
  logic [7:0]               cur_x;
  logic [7:0]               cur_y;
  logic [FB_ADDR_WIDTH-1:0] cur_base;
  logic [7:0]               word;
  logic                     word_ready;

  // A start in the same cycle as a pixel makes that pixel (0,0), so the
  // position used for this cycle's pixel is forced to the frame origin.
  always_comb begin
    start    = 1'b0;
    accept   = 1'b0;
    clear    = 1'b0;
    cur_x    = x;
    cur_y    = y;
    cur_base = row_base;
    if (bus.enable_in) begin
      start  = bus.frame_start_in;
      accept = bus.pixel_valid_in && (start || (state == ACTIVE));
    end
    clear = !bus.enable_in || start;
    if (start) begin
      cur_x    = 8'd0;
      cur_y    = 8'd0;
      cur_base = '0;
    end
  end

  pixel_packer u_packer (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .clear      (clear),
    .accept     (accept),
    .shade      (bus.pixel_in),
    .slot       (cur_x[1:0]),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      x          <= 8'd0;
      y          <= 8'd0;
      row_base   <= '0;
      fb_addr    <= '0;
      fb_data    <= 8'h00;
      fb_we      <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (!bus.enable_in) begin
        state    <= IDLE;
        x        <= 8'd0;
        y        <= 8'd0;
        row_base <= '0;
      end else begin
        if (start) begin
          state    <= ACTIVE;
          x        <= 8'd0;
          y        <= 8'd0;
          row_base <= '0;
          overrun  <= 1'b0;
        end else if ((state == DONE) && bus.pixel_valid_in) begin
          overrun <= 1'b1;
        end

        if (accept) begin
          if (word_ready) begin
            fb_we   <= 1'b1;
            fb_data <= word;
            fb_addr <= cur_base + FB_ADDR_WIDTH'(cur_x[7:2]);
          end
          // X_MAX is a multiple of 4, so the last column always completes a word.
          if (cur_x == LAST_COL) begin
            x         <= 8'd0;
            line_done <= 1'b1;
            if (cur_y == LAST_ROW) begin
              state      <= DONE;
              frame_done <= 1'b1;
              y          <= cur_y;
            end else begin
              y        <= cur_y + 8'd1;
              row_base <= cur_base + WORDS_PER_LINE;
            end
          end else begin
            x <= cur_x + 8'd1;
          end
        end
      end
    end
  end

  assign bus.fb_addr_out    = fb_addr;
  assign bus.fb_data_out    = fb_data;
  assign bus.fb_we_out      = fb_we;
  assign bus.x_out          = x;
  assign bus.y_out          = y;
  assign bus.line_done_out  = line_done;
  assign bus.frame_done_out = frame_done;
  assign bus.overrun_out    = overrun;
  assign bus.state          = state;

endmodule
